// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch PC stage.
package if_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_stage_if.sv
// Fetch-stage bus: address-generator inputs, instruction memory and IF/ID outputs.
interface if_pc_stage_if;
  import if_pkg::*;

  logic [31:0]        next_pc;
  logic               flush;
  logic               stall;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic [31:0]        pc;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] ifid_instr;
  logic [31:0]        ifid_pc4;
  logic               ifid_valid;
  logic [15:0]        miss_count;

  modport master (
    output next_pc, flush, stall, imem_ready, imem_rdata,
    input  pc, imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid, miss_count
  );

  modport slave (
    input  next_pc, flush, stall, imem_ready, imem_rdata,
    output pc, imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid, miss_count
  );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; clear wins over load and forces the NOP word.
module ifid_reg
  import if_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc4_q;
  logic               valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_pc_stage.sv
// PC register, fetch/hold FSM and miss counter feeding the IF/ID register.
module if_pc_stage
  import if_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  if_pc_stage_if.slave bus
);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic [31:0]        buf_pc4_q, buf_pc4_d;
  logic [15:0]        miss_q, miss_d;

  logic               ld;
  logic               clr;
  logic [INSTR_W-1:0] ld_instr;
  logic [31:0]        ld_pc4;
  logic [31:0]        pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    miss_d      = miss_q;
    ld          = 1'b0;
    clr         = 1'b0;
    ld_instr    = bus.imem_rdata;
    ld_pc4      = pc_plus4;

    unique case (state_q)
      FETCH: begin
        if (!bus.imem_ready && (miss_q != 16'hFFFF)) miss_d = miss_q + 16'd1;
        if (bus.flush) begin
          clr  = 1'b1;
          pc_d = align_pc(bus.next_pc);
        end else if (bus.imem_ready && !bus.stall) begin
          ld   = 1'b1;
          pc_d = align_pc(bus.next_pc);
        end else if (bus.imem_ready) begin
          buf_instr_d = bus.imem_rdata;
          buf_pc4_d   = pc_plus4;
          state_d     = HOLD;
        end else if (!bus.stall) begin
          clr = 1'b1;
        end
      end
      HOLD: begin
        // The word already returned for pc; no refetch, just release or drop it.
        if (bus.flush) begin
          clr     = 1'b1;
          pc_d    = align_pc(bus.next_pc);
          state_d = FETCH;
        end else if (!bus.stall) begin
          ld       = 1'b1;
          ld_instr = buf_instr_q;
          ld_pc4   = buf_pc4_q;
          pc_d     = align_pc(bus.next_pc);
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= align_pc(RESET_PC);
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      miss_q      <= miss_d;
    end
  end

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .clear_i (clr),
    .instr_i (ld_instr),
    .pc4_i   (ld_pc4),
    .instr_o (bus.ifid_instr),
    .pc4_o   (bus.ifid_pc4),
    .valid_o (bus.ifid_valid)
  );

  assign bus.pc         = pc_q;
  assign bus.imem_addr  = pc_q;
  assign bus.imem_req   = (state_q == FETCH) && !rst;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed scenarios plus a randomized run against a queue-based fetch model.
module tb_if_pc_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  if_pc_stage_if bus ();

  if_pc_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: at most one buffered {instr, pc4} word; empty queue means fetching.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_miss;
  logic [63:0] m_buf[$];

  task automatic drive(input logic r, input logic f, input logic s, input logic rdy,
                       input logic [31:0] rd, input logic [31:0] np);
    rst = r; bus.flush = f; bus.stall = s; bus.imem_ready = rdy;
    bus.imem_rdata = rd; bus.next_pc = np;
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    logic [63:0] e;
    tgt = {bus.next_pc[31:2], 2'b00};
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_instr = NOP; m_pc4 = 0; m_miss = 0; m_buf.delete();
    end else if (m_buf.size() == 0) begin
      if (!bus.imem_ready && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      if (bus.flush) begin
        m_pc = tgt; m_valid = 0; m_instr = NOP;
      end else if (bus.imem_ready && !bus.stall) begin
        m_instr = bus.imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = tgt;
      end else if (bus.imem_ready) begin
        m_buf.push_back({bus.imem_rdata, m_pc + 32'd4});
      end else if (!bus.stall) begin
        m_valid = 0; m_instr = NOP;
      end
    end else begin
      if (bus.flush) begin
        m_buf.delete(); m_valid = 0; m_instr = NOP; m_pc = tgt;
      end else if (!bus.stall) begin
        e = m_buf.pop_front();
        m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1; m_pc = tgt;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 32'hDEAD_BEEF, 32'h100);
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_gated got %0b want 0", bus.imem_req); end
    tick(); tick();
    drive(0, 0, 0, 1, 32'h1111_0000, 32'h4);
    #1;
    checks++;
    if (bus.pc !== RST_PC || bus.imem_addr !== RST_PC) begin errors++; $display("FAIL reset_pc got %h/%h want %h", bus.pc, bus.imem_addr, RST_PC); end
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP || bus.ifid_pc4 !== 32'h0) begin
      errors++; $display("FAIL reset_ifid got v=%0b i=%h p=%h want 0/%h/0", bus.ifid_valid, bus.ifid_instr, bus.ifid_pc4, NOP);
    end
    checks++;
    if (bus.miss_count !== 16'h0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_miss_req got %h/%0b want 0/1", bus.miss_count, bus.imem_req); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.pc !== 32'(4 * i)) begin errors++; $display("FAIL free_run_pc got %h want %h", bus.pc, 32'(4 * i)); end
      drive(0, 0, 0, 1, 32'h1111_0000 + 32'(i), bus.pc + 32'd4);
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_pc4 !== 32'(4 * i + 4) || bus.ifid_instr !== 32'h1111_0000 + 32'(i)) begin
        errors++; $display("FAIL free_run_ifid got v=%0b p=%h i=%h want 1/%h/%h", bus.ifid_valid, bus.ifid_pc4, bus.ifid_instr, 32'(4 * i + 4), 32'h1111_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 32'hBAD0_0000, 32'h14);
      tick();
      checks++;
      if (bus.pc !== 32'h10 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin
        errors++; $display("FAIL miss_hold got pc=%h v=%0b i=%h want 10/0/%h", bus.pc, bus.ifid_valid, bus.ifid_instr, NOP);
      end
    end
    checks++;
    if (bus.miss_count !== 16'd3) begin errors++; $display("FAIL miss_count got %0d want 3", bus.miss_count); end
    drive(0, 0, 0, 1, 32'hABCD_0010, 32'h14);
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_pc4 !== 32'h14 || bus.ifid_instr !== 32'hABCD_0010 || bus.pc !== 32'h14) begin
      errors++; $display("FAIL miss_return got v=%0b p=%h i=%h pc=%h want 1/14/abcd0010/14", bus.ifid_valid, bus.ifid_pc4, bus.ifid_instr, bus.pc);
    end
  endtask

  task automatic test_stall_return();
    drive(0, 0, 1, 1, 32'h2002_0005, 32'h18);
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.imem_req !== 1'b0 || bus.pc !== 32'h14 || bus.ifid_pc4 !== 32'h14 || bus.ifid_instr !== 32'hABCD_0010) begin
        errors++; $display("FAIL stall_hold got req=%0b pc=%h p=%h i=%h want 0/14/14/abcd0010", bus.imem_req, bus.pc, bus.ifid_pc4, bus.ifid_instr);
      end
      drive(0, 0, (i == 0), 1, 32'h5555_5555, 32'h18);
      tick();
    end
    checks++;
    if (bus.ifid_instr !== 32'h2002_0005 || bus.ifid_pc4 !== 32'h18 || bus.ifid_valid !== 1'b1 || bus.pc !== 32'h18 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL stall_release got i=%h p=%h v=%0b pc=%h req=%0b want 20020005/18/1/18/1", bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.pc, bus.imem_req);
    end
  endtask

  task automatic test_flush_stall();
    drive(0, 1, 1, 1, 32'h7777_7777, 32'h40);
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP || bus.pc !== 32'h40 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL flush_stall got v=%0b i=%h pc=%h req=%0b want 0/%h/40/1", bus.ifid_valid, bus.ifid_instr, bus.pc, bus.imem_req, NOP);
    end
  endtask

  task automatic test_wrap_align();
    drive(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 1, 32'hCAFE_F00D, 32'h0000_0023);
    tick();
    checks++;
    if (bus.ifid_pc4 !== 32'h0 || bus.ifid_instr !== 32'hCAFE_F00D || bus.pc !== 32'h20) begin
      errors++; $display("FAIL wrap_align got p=%h i=%h pc=%h want 0/cafef00d/20", bus.ifid_pc4, bus.ifid_instr, bus.pc);
    end
  endtask

  task automatic test_reset_hold();
    drive(0, 0, 1, 1, 32'h9999_0001, 32'h24);
    tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL enter_hold got req=%0b want 0", bus.imem_req); end
    drive(1, 0, 1, 1, 32'h0, 32'h24);
    tick();
    drive(0, 0, 1, 0, 32'h0, 32'h4);
    #1;
    checks++;
    if (bus.pc !== RST_PC || bus.ifid_valid !== 1'b0 || bus.miss_count !== 16'h0 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL reset_hold got pc=%h v=%0b m=%0d req=%0b want %h/0/0/1", bus.pc, bus.ifid_valid, bus.miss_count, bus.imem_req, RST_PC);
    end
    drive(0, 0, 0, 0, 32'h0, 32'h4);
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.miss_count !== 16'd1) begin
      errors++; $display("FAIL reset_hold_buf got v=%0b m=%0d want 0/1", bus.ifid_valid, bus.miss_count);
    end
  endtask

  task automatic test_random();
    logic f, s, rdy;
    logic [31:0] np;
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 400; i++) begin
      f   = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      np  = f ? $urandom : (m_pc + 32'd4) | 32'($urandom_range(0, 3));
      drive(($urandom_range(0, 99) == 0), f, s, rdy, $urandom, np);
      #1;
      checks++;
      if (bus.imem_req !== (m_buf.size() == 0 && !rst) || bus.imem_addr !== m_pc) begin
        errors++; $display("FAIL rand_req cyc %0d got req=%0b addr=%h want %0b/%h", i, bus.imem_req, bus.imem_addr, (m_buf.size() == 0 && !rst), m_pc);
      end
      tick();
      checks++;
      if (bus.pc !== m_pc || bus.ifid_valid !== m_valid || bus.ifid_instr !== m_instr ||
          bus.ifid_pc4 !== m_pc4 || bus.miss_count !== m_miss) begin
        errors++;
        $display("FAIL rand_state cyc %0d got pc=%h v=%0b i=%h p=%h m=%0d want %h/%0b/%h/%h/%0d",
                 i, bus.pc, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc4, bus.miss_count,
                 m_pc, m_valid, m_instr, m_pc4, m_miss);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_miss();
    test_stall_return();
    test_flush_stall();
    test_wrap_align();
    test_reset_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
